// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared state encodings, ASCII command/response codes and decode helpers for uart_cmd_sequencer.
package uart_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIGIT = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_REPLY = 3'd4,
    ST_ECHO  = 3'd5
  } state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic play_pause;
    logic reverse;
  } pulse_t;

  localparam logic [7:0] CMD_UP  = 8'h2B;
  localparam logic [7:0] CMD_DN  = 8'h2D;
  localparam logic [7:0] CMD_PP  = 8'h70;
  localparam logic [7:0] CMD_REV = 8'h72;
  localparam logic [7:0] RSP_OK  = 8'h6B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  localparam logic [7:0] DIGIT_0 = 8'h30;
  localparam logic [7:0] DIGIT_9 = 8'h39;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= DIGIT_0) && (b <= DIGIT_9);
  endfunction

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_UP) || (b == CMD_DN) || (b == CMD_PP) || (b == CMD_REV);
  endfunction

  function automatic logic is_tempo(input logic [7:0] b);
    return (b == CMD_UP) || (b == CMD_DN);
  endfunction

  function automatic pulse_t cmd_pulse(input logic [7:0] cmd);
    pulse_t p;
    p = '0;
    case (cmd)
      CMD_UP:  p.up         = 1'b1;
      CMD_DN:  p.down       = 1'b1;
      CMD_PP:  p.play_pause = 1'b1;
      CMD_REV: p.reverse    = 1'b1;
      default: p            = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_timer.sv
// Clearable up-counter that stops at a programmable limit and flags reaching it.
module uart_cmd_sequencer_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_c_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == limit_i);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses single-byte ASCII UART commands into control pulses and answers with a status byte.
// Define UART_CMD_ECHO_EN to echo every accepted command byte before it is processed.
module uart_cmd_sequencer
  import uart_cmd_sequencer_pkg::*;
#(
  parameter int unsigned PULSE_GAP      = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 125_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tempo_up,
  output logic       tempo_down,
  output logic       play_pause,
  output logic       reverse,
  output logic       busy
);

  localparam int unsigned TMR_MAX = (PULSE_GAP > TIMEOUT_CYCLES) ? PULSE_GAP : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(PULSE_GAP - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [7:0]  cmd_q, cmd_d;
  pulse_t      pulse_q, pulse_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rx_ready_q, rx_ready_d;
  logic        busy_q, busy_d;

  logic        rx_fire;
  logic        proc_valid;
  logic [7:0]  proc_byte;
  logic        proc_from_digit;

  logic             tmr_run;
  logic             tmr_tc;
  logic [TMR_W-1:0] tmr_limit;

`ifdef UART_CMD_ECHO_EN
  logic [7:0] echo_byte_q, echo_byte_d;
  logic       echo_digit_q, echo_digit_d;
`endif

  // One timer serves both the inter-pulse gap and the digit-prefix timeout.
  assign tmr_run   = (state_q == ST_GAP) || (state_q == ST_DIGIT);
  assign tmr_limit = (state_q == ST_GAP) ? GAP_LAST : TIMEOUT_LAST;

  uart_cmd_sequencer_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (!tmr_run),
    .en_i    (tmr_run),
    .limit_i (tmr_limit),
    .tc_c_o  (tmr_tc)
  );

  assign rx_fire = rx_valid && rx_ready_q;

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    cmd_d           = cmd_q;
    pulse_d         = '0;
    tx_valid_d      = tx_valid_q;
    tx_data_d       = tx_data_q;
    rx_ready_d      = 1'b0;
    busy_d          = 1'b0;
    proc_valid      = 1'b0;
    proc_byte       = rx_data;
    proc_from_digit = (state_q == ST_DIGIT);

`ifdef UART_CMD_ECHO_EN
    echo_byte_d     = echo_byte_q;
    echo_digit_d    = echo_digit_q;
    proc_valid      = (state_q == ST_ECHO) && tx_ready;
    proc_byte       = echo_byte_q;
    proc_from_digit = echo_digit_q;
    if (rx_fire) begin
      state_d      = ST_ECHO;
      tx_valid_d   = 1'b1;
      tx_data_d    = rx_data;
      echo_byte_d  = rx_data;
      echo_digit_d = (state_q == ST_DIGIT);
    end
    if (proc_valid) begin
      tx_valid_d = 1'b0;
    end
`else
    proc_valid = rx_fire;
`endif

    if (proc_valid) begin
      if (!proc_from_digit && is_cmd(proc_byte)) begin
        cmd_d   = proc_byte;
        count_d = 4'd1;
        state_d = ST_PULSE;
      end else if (!proc_from_digit && is_digit(proc_byte)) begin
        count_d = 4'(proc_byte - DIGIT_0);
        state_d = ST_DIGIT;
      end else if (proc_from_digit && is_tempo(proc_byte)) begin
        cmd_d   = proc_byte;
        state_d = ST_PULSE;
      end else begin
        tx_valid_d = 1'b1;
        tx_data_d  = RSP_ERR;
        state_d    = ST_REPLY;
      end
    end else begin
      case (state_q)
        ST_DIGIT: begin
          if (!rx_fire && tmr_tc) begin
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_ERR;
            state_d    = ST_REPLY;
          end
        end
        ST_PULSE: begin
          // A '0' prefix arrives here with count 0: nothing to emit, just acknowledge.
          count_d = (count_q == 4'd0) ? 4'd0 : count_q - 4'd1;
          if (count_d != 4'd0) begin
            state_d = ST_GAP;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_OK;
            state_d    = ST_REPLY;
          end
        end
        ST_GAP: begin
          if (tmr_tc) begin
            state_d = ST_PULSE;
          end
        end
        ST_REPLY: begin
          if (tx_ready) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    // Pulse registers load on entry to PULSE so the pulse lines up with that state.
    if ((state_d == ST_PULSE) && (count_d != 4'd0)) begin
      pulse_d = cmd_pulse(cmd_d);
    end
    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_DIGIT);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      cmd_q      <= '0;
      pulse_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      rx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cmd_q      <= cmd_d;
      pulse_q    <= pulse_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
    end
  end

`ifdef UART_CMD_ECHO_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_byte_q  <= '0;
      echo_digit_q <= 1'b0;
    end else begin
      echo_byte_q  <= echo_byte_d;
      echo_digit_q <= echo_digit_d;
    end
  end
`endif

  assign rx_ready   = rx_ready_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign tempo_up   = pulse_q.up;
  assign tempo_down = pulse_q.down;
  assign play_pause = pulse_q.play_pause;
  assign reverse    = pulse_q.reverse;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed self-checking bench for uart_cmd_sequencer with PULSE_GAP=4, TIMEOUT_CYCLES=50.
module tb_uart_cmd_sequencer;

  localparam int unsigned PULSE_GAP      = 4;
  localparam int unsigned TIMEOUT_CYCLES = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       tempo_up, tempo_down, play_pause, reverse, busy;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(
    .PULSE_GAP      (PULSE_GAP),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tempo_up   (tempo_up),
    .tempo_down (tempo_down),
    .play_pause (play_pause),
    .reverse    (reverse),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observed traffic, only ever written here; the stimulus works on deltas.
  int         cyc = 0;
  int         n_up = 0, n_dn = 0, n_pp = 0, n_rev = 0, n_multi = 0;
  int         up_at[$];
  logic [7:0] tx_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (tempo_up)   begin n_up = n_up + 1; up_at.push_back(cyc); end
    if (tempo_down) n_dn = n_dn + 1;
    if (play_pause) n_pp = n_pp + 1;
    if (reverse)    n_rev = n_rev + 1;
    if ((int'(tempo_up) + int'(tempo_down) + int'(play_pause) + int'(reverse)) > 1) n_multi = n_multi + 1;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    logic done;
    done     = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (rx_ready) done = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("rx_accept", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!busy && !tx_valid) ok = 1'b1;
      else @(negedge clk);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  function automatic logic [7:0] tx_at(input int idx);
    if (idx < tx_q.size()) return tx_q[idx];
    return 8'hXX;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_up, b_dn, b_pp, b_rev, b_tx, b_at, bad;
    int d1, d2;

    // Reset state
    tick(3);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({tempo_up, tempo_down, play_pause, reverse}), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);

`ifndef UART_CMD_ECHO_EN
    // 1: single 'p'
    b_pp = n_pp; b_tx = tx_q.size();
    send_byte(8'h70);
    check("t1_pp_pulse", 32'(play_pause), 32'd1);
    check("t1_other_pulse", 32'({tempo_up, tempo_down, reverse}), 32'd0);
    check("t1_rx_ready_low", 32'(rx_ready), 32'd0);
    tick(1);
    check("t1_pp_one_cycle", 32'(play_pause), 32'd0);
    check("t1_tx_valid", 32'(tx_valid), 32'd1);
    check("t1_tx_data", 32'(tx_data), 32'h6B);
    tick(1);
    check("t1_tx_drop", 32'(tx_valid), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_pp_count", 32'(n_pp - b_pp), 32'd1);
    check("t1_tx_count", 32'(tx_q.size() - b_tx), 32'd1);

    // 2: '3','+' -> three tempo_up pulses 5 cycles apart
    b_up = n_up; b_at = up_at.size(); b_tx = tx_q.size(); b_dn = n_dn;
    send_byte(8'h33);
    send_byte(8'h2B);
    wait_idle("t2_idle");
    check("t2_up_count", 32'(n_up - b_up), 32'd3);
    check("t2_dn_count", 32'(n_dn - b_dn), 32'd0);
    d1 = (up_at.size() >= b_at + 3) ? up_at[b_at+1] - up_at[b_at] : -1;
    d2 = (up_at.size() >= b_at + 3) ? up_at[b_at+2] - up_at[b_at+1] : -1;
    check("t2_spacing1", 32'(d1), 32'd5);
    check("t2_spacing2", 32'(d2), 32'd5);
    check("t2_tx_count", 32'(tx_q.size() - b_tx), 32'd1);
    check("t2_tx_byte", 32'(tx_at(b_tx)), 32'h6B);
    check("t2_busy_low", 32'(busy), 32'd0);

    // 3: unknown byte, and digit followed by a non-tempo command
    b_up = n_up; b_dn = n_dn; b_pp = n_pp; b_rev = n_rev; b_tx = tx_q.size();
    send_byte(8'h78);
    check("t3_err_valid", 32'(tx_valid), 32'd1);
    check("t3_err_data", 32'(tx_data), 32'h3F);
    wait_idle("t3_idle_a");
    send_byte(8'h35);
    send_byte(8'h70);
    wait_idle("t3_idle_b");
    check("t3_no_pulses", 32'((n_up - b_up) + (n_dn - b_dn) + (n_pp - b_pp) + (n_rev - b_rev)), 32'd0);
    check("t3_tx_count", 32'(tx_q.size() - b_tx), 32'd2);
    check("t3_tx_byte1", 32'(tx_at(b_tx + 1)), 32'h3F);

    // 4: digit prefix times out after TIMEOUT_CYCLES
    send_byte(8'h32);
    tick(10);
    check("t4_digit_busy", 32'(busy), 32'd1);
    check("t4_digit_rx_ready", 32'(rx_ready), 32'd1);
    tick(39);
    check("t4_before_timeout", 32'(tx_valid), 32'd0);
    tick(1);
    check("t4_timeout_valid", 32'(tx_valid), 32'd1);
    check("t4_timeout_data", 32'(tx_data), 32'h3F);
    tick(1);
    check("t4_back_idle", 32'({busy, rx_ready}), 32'b01);

    // 5: reply held by tx backpressure, queued rx byte waits
    b_rev = n_rev; b_tx = tx_q.size();
    tx_ready = 1'b0;
    send_byte(8'h70);
    rx_data  = 8'h72;
    rx_valid = 1'b1;
    tick(1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h6B || rx_ready !== 1'b0) bad++;
      tick(1);
    end
    check("t5_hold_stable", 32'(bad), 32'd0);
    check("t5_rev_before", 32'(n_rev - b_rev), 32'd0);
    tx_ready = 1'b1;
    tick(1);
    check("t5_tx_drop", 32'(tx_valid), 32'd0);
    check("t5_rx_ready", 32'(rx_ready), 32'd1);
    tick(1);
    check("t5_rev_pulse", 32'(reverse), 32'd1);
    rx_valid = 1'b0;
    wait_idle("t5_idle");
    check("t5_rev_count", 32'(n_rev - b_rev), 32'd1);
    check("t5_tx_count", 32'(tx_q.size() - b_tx), 32'd2);

    // 6: reset during the gap of '9-'
    b_dn = n_dn; b_tx = tx_q.size();
    send_byte(8'h39);
    send_byte(8'h2D);
    check("t6_first_dn", 32'(tempo_down), 32'd1);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("t6_rst_outputs", 32'({tempo_up, tempo_down, play_pause, reverse, tx_valid, busy}), 32'd0);
    check("t6_rst_tx_data", 32'(tx_data), 32'h00);
    check("t6_rst_rx_ready", 32'(rx_ready), 32'd1);
    rst_n = 1'b1;
    tick(20);
    check("t6_dn_count", 32'(n_dn - b_dn), 32'd1);
    check("t6_no_reply", 32'(tx_q.size() - b_tx), 32'd0);
    check("t6_idle", 32'({busy, rx_ready}), 32'b01);
`else
    // Echo build: 'r' yields the echo then the reply
    b_rev = n_rev; b_tx = tx_q.size();
    send_byte(8'h72);
    check("e_echo_valid", 32'(tx_valid), 32'd1);
    check("e_echo_data", 32'(tx_data), 32'h72);
    check("e_echo_rx_ready", 32'(rx_ready), 32'd0);
    tick(1);
    check("e_rev_pulse", 32'(reverse), 32'd1);
    wait_idle("e_idle");
    check("e_rev_count", 32'(n_rev - b_rev), 32'd1);
    check("e_tx_count", 32'(tx_q.size() - b_tx), 32'd2);
    check("e_tx_byte0", 32'(tx_at(b_tx)), 32'h72);
    check("e_tx_byte1", 32'(tx_at(b_tx + 1)), 32'h6B);
    b_up = n_up; b_pp = n_pp;
    check("e_no_other", 32'((n_up - b_up) + (n_pp - b_pp)), 32'd0);
`endif

    check("one_hot_pulses", 32'(n_multi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
